// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring-subtract (divide) step per clock,
// followed by a single sign-correction cycle; results land in HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed operands are reduced to magnitudes; MIN negates to itself, which is its correct unsigned magnitude.
    assign mag_a = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op_signed && b[WIDTH-1]) ? -b : b;

    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // Multiply keeps the multiplier in the low half of acc and shifts the partial product in from the top.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opnd_q};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_div;
                    dz_d     = 1'b0;
                    if (op_div && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d   = CALC;
                        cnt_d     = '0;
                        opnd_d    = op_div ? mag_b : mag_a;
                        acc_d     = {{WIDTH{1'b0}}, mag_b};
                        rem_d     = '0;
                        quo_d     = mag_a;
                        neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = op_signed && a[WIDTH-1];
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    rem_d = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                state_d = DONE;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8, checked against a wide-integer arithmetic model.
module tb_mult_div_unit;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        bit          dz;
        int          due;
        int          busy_cycles;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        reset32, start32, opd32, ops32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        reset8, start8, opd8, ops8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    exp_t        q32[$];
    exp_t        q8[$];
    int          run32 = 0;
    int          run8 = 0;
    bit          prev_done32 = 1'b0;
    bit          prev_done8 = 1'b0;
    logic [63:0] last_hi[2];
    logic [63:0] last_lo[2];

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset32), .start(start32), .op_div(opd32), .op_signed(ops32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op_div(opd8), .op_signed(ops8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed results come from true integer arithmetic on sign-extended 128-bit values.
    function automatic void refModel(input int w, input bit dv, input bit sg,
                                     input logic [63:0] av, input logic [63:0] bv,
                                     input logic [63:0] ph, input logic [63:0] pl,
                                     output logic [63:0] eh, output logic [63:0] el, output bit dz);
        logic signed [127:0] sa, sb, r, m;
        logic [127:0]        hv;
        logic [63:0]         mask;
        mask = (64'd1 << w) - 64'd1;
        sa = $signed({64'd0, av & mask});
        sb = $signed({64'd0, bv & mask});
        if (sg && av[w-1]) sa = sa - (128'sd1 <<< w);
        if (sg && bv[w-1]) sb = sb - (128'sd1 <<< w);
        dz = 1'b0;
        if (!dv) begin
            r  = sa * sb;
            hv = r >>> w;
            el = r[63:0] & mask;
            eh = hv[63:0] & mask;
        end else if ((bv & mask) == 64'd0) begin
            dz = 1'b1;
            eh = ph;
            el = pl;
        end else begin
            r  = sa / sb;
            m  = sa % sb;
            el = r[63:0] & mask;
            eh = m[63:0] & mask;
        end
    endfunction

    task automatic driveInputs(input int sel, input bit st, input bit dv, input bit sg,
                               input logic [63:0] av, input logic [63:0] bv);
        if (sel == 0) begin
            start32 = st; opd32 = dv; ops32 = sg; a32 = av[31:0]; b32 = bv[31:0];
        end else begin
            start8 = st; opd8 = dv; ops8 = sg; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    task automatic applyStimulus(input int sel, input bit dv, input bit sg,
                                 input logic [63:0] av, input logic [63:0] bv, input bit pulse_mid);
        exp_t e;
        int   w;
        int   lat;
        bit   got;
        w = (sel == 0) ? 32 : 8;
        refModel(w, dv, sg, av, bv, last_hi[sel], last_lo[sel], e.hi, e.lo, e.dz);
        last_hi[sel]  = e.hi;
        last_lo[sel]  = e.lo;
        lat           = e.dz ? 1 : w + 2;
        e.busy_cycles = e.dz ? 0 : w + 1;
        @(negedge clk);
        driveInputs(sel, 1'b1, dv, sg, av, bv);
        @(posedge clk);
        #1;
        driveInputs(sel, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1),
                    {$urandom, $urandom}, {$urandom, $urandom});
        e.due = cyc + lat - 1;
        if (sel == 0) q32.push_back(e);
        else          q8.push_back(e);
        got = 1'b0;
        for (int i = 0; i < lat + 8 && !got; i++) begin
            @(negedge clk);
            if ((sel == 0) ? done32 : done8) got = 1'b1;
            if (pulse_mid && i == 5)
                driveInputs(sel, 1'b1, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            if (pulse_mid && i == 6)
                driveInputs(sel, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: done not seen, got 0 expected 1 (sel %0d)", sel);
        end
    endtask

    task automatic resetMidMultiply();
        @(negedge clk);
        driveInputs(0, 1'b1, 1'b0, 1'b0, 64'd123456, 64'd789);
        @(posedge clk);
        #1;
        driveInputs(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (10) @(negedge clk);
        reset32 = 1'b1;
        @(posedge clk);
        #1;
        reset32    = 1'b0;
        run32      = 0;
        last_hi[0] = 64'd0;
        last_lo[0] = 64'd0;
        @(negedge clk);
        checkOutput("rst_mid_busy", {63'd0, busy32}, 64'd0);
        checkOutput("rst_mid_done", {63'd0, done32}, 64'd0);
        checkOutput("rst_mid_hi", {32'd0, hi32}, 64'd0);
        checkOutput("rst_mid_lo", {32'd0, lo32}, 64'd0);
        repeat (40) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy32 === 1'b1) run32++;
        if (dz32 === 1'b1 && done32 !== 1'b1) checkOutput("dz32_alone", 64'd1, 64'd0);
        if (done32 === 1'b1) begin
            checkOutput("done32_twice", {63'd0, prev_done32}, 64'd0);
            if (q32.size() == 0) begin
                checkOutput("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                checkOutput("hi32", {32'd0, hi32}, e.hi);
                checkOutput("lo32", {32'd0, lo32}, e.lo);
                checkOutput("div_zero32", {63'd0, dz32}, {63'd0, e.dz});
                checkOutput("latency32", 64'(cyc), 64'(e.due));
                checkOutput("busy_len32", 64'(run32), 64'(e.busy_cycles));
            end
            run32 = 0;
        end
        prev_done32 = (done32 === 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy8 === 1'b1) run8++;
        if (dz8 === 1'b1 && done8 !== 1'b1) checkOutput("dz8_alone", 64'd1, 64'd0);
        if (done8 === 1'b1) begin
            checkOutput("done8_twice", {63'd0, prev_done8}, 64'd0);
            if (q8.size() == 0) begin
                checkOutput("done8_unexpected", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("hi8", {56'd0, hi8}, e.hi);
                checkOutput("lo8", {56'd0, lo8}, e.lo);
                checkOutput("div_zero8", {63'd0, dz8}, {63'd0, e.dz});
                checkOutput("latency8", 64'(cyc), 64'(e.due));
                checkOutput("busy_len8", 64'(run8), 64'(e.busy_cycles));
            end
            run8 = 0;
        end
        prev_done8 = (done8 === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          dv, sg;
        logic [63:0] av, bv;
        last_hi[0] = 64'd0; last_lo[0] = 64'd0;
        last_hi[1] = 64'd0; last_lo[1] = 64'd0;
        reset32 = 1'b1; reset8 = 1'b1;
        driveInputs(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        driveInputs(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        reset32 = 1'b0; reset8 = 1'b0;
        checkOutput("rst_busy32", {63'd0, busy32}, 64'd0);
        checkOutput("rst_done32", {63'd0, done32}, 64'd0);
        checkOutput("rst_dz32", {63'd0, dz32}, 64'd0);
        checkOutput("rst_hi32", {32'd0, hi32}, 64'd0);
        checkOutput("rst_lo32", {32'd0, lo32}, 64'd0);
        checkOutput("rst_busy8", {63'd0, busy8}, 64'd0);
        checkOutput("rst_hi8", {56'd0, hi8}, 64'd0);
        checkOutput("rst_lo8", {56'd0, lo8}, 64'd0);

        applyStimulus(0, 1'b0, 1'b1, 64'd7, 64'hFFFFFFFD, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 64'hFFFFFFF9, 64'd2, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 64'd100, 64'd7, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 64'd55, 64'd0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 64'hDEADBEEF, 64'd0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 64'h80000000, 64'hFFFFFFFF, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 64'h80000000, 64'h80000000, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 64'd9, 64'hFFFFFFFE, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 64'h12345678, 64'hFEDCBA98, 1'b1);

        for (int i = 0; i < 20; i++) begin
            dv = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            av = {32'd0, $urandom};
            case ($urandom_range(0, 7))
                0:       bv = 64'd0;
                1:       bv = 64'hFFFFFFFF;
                2:       bv = 64'($urandom_range(1, 9));
                default: bv = {32'd0, $urandom};
            endcase
            applyStimulus(0, dv, sg, av, bv, 1'b0);
        end

        resetMidMultiply();
        applyStimulus(0, 1'b0, 1'b1, 64'hFFFFFFF6, 64'd25, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 64'd1000, 64'hFFFFFFFD, 1'b0);

        applyStimulus(1, 1'b0, 1'b1, 64'd7, 64'hFD, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 64'hF9, 64'd2, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 64'h80, 64'hFF, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 64'd200, 64'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            dv = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            av = 64'($urandom_range(0, 255));
            bv = 64'($urandom_range(0, 255));
            applyStimulus(1, dv, sg, av, bv, 1'b0);
        end

        repeat (5) @(negedge clk);
        if (q32.size() != 0) checkOutput("pending32", 64'(q32.size()), 64'd0);
        if (q8.size() != 0) checkOutput("pending8", 64'(q8.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
